bsg_round_robin_fifo_to_fifo_buffered: RTL

//  Striping crossbar: moves words from num_in_p valid/yumi input FIFOs to num_out_p valid/ready

---
 rtl/bsg_rr_f2f_buf_pkg.sv | 25 ++
 rtl/bsg_rr_f2f_obuf.sv | 59 +++++
 rtl/bsg_round_robin_fifo_to_fifo_buffered.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bsg_rr_f2f_buf_pkg.sv
// Shared types and helpers for the buffered round-robin FIFO-to-FIFO crossbar.
package bsg_rr_f2f_buf_pkg;

    // Entries held per output channel
    localparam int obuf_depth_lp = 2;

    typedef logic [1:0] obuf_cnt_t;
    typedef int         rr_ptr_t;

    // Pointer register width: at least one bit, even for a single channel
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Modular advance; ptr < n and k <= n, so one conditional subtract suffices
    function automatic rr_ptr_t rr_add(input rr_ptr_t ptr, input rr_ptr_t k, input rr_ptr_t n);
        rr_ptr_t sum;
        sum = ptr + k;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/bsg_rr_f2f_obuf.sv
// Two-entry valid/ready output buffer. free_o comes from the registered count only,
// so a full buffer does not accept a write in the same cycle it is popped.
module bsg_rr_f2f_obuf
    import bsg_rr_f2f_buf_pkg::*;
#(
    parameter int width_p = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               free_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);

    logic [width_p-1:0] mem_reg [obuf_depth_lp];
    logic               wr_ptr_reg;
    logic               rd_ptr_reg;
    obuf_cnt_t          count_reg;
    logic               push;
    logic               pop;

    assign free_o  = (count_reg < obuf_cnt_t'(obuf_depth_lp));
    assign valid_o = (count_reg != '0);
    assign push    = v_i & free_o;
    assign pop     = valid_o & ready_i;
    assign data_o  = mem_reg[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; push+pop together leaves the count unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage; contents need no reset because the count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_round_robin_fifo_to_fifo_buffered.sv
// Striping crossbar: moves up to min(NI,NO) words per cycle from round-robin input
// FIFO heads into round-robin two-entry output buffers, preserving global order.
module bsg_round_robin_fifo_to_fifo_buffered
    import bsg_rr_f2f_buf_pkg::*;
#(
    parameter int  width_p   = 16,
    parameter int  num_in_p  = 2,
    parameter int  num_out_p = 1,
    localparam int lg_in_lp  = $clog2(num_in_p + 1),
    localparam int lg_out_lp = $clog2(num_out_p + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [num_in_p-1:0]           valid_i,
    input  logic [num_in_p*width_p-1:0]   data_i,
    output logic [num_in_p-1:0]           yumi_o,
    input  logic [lg_in_lp-1:0]           in_active_i,
    input  logic [lg_out_lp-1:0]          out_active_i,
    output logic [num_out_p-1:0]          valid_o,
    output logic [num_out_p*width_p-1:0]  data_o,
    input  logic [num_out_p-1:0]          ready_i,
    output logic [lg_in_lp-1:0]           xfer_cnt_o
);

    localparam int iptr_w_lp = ptr_width(num_in_p);
    localparam int optr_w_lp = ptr_width(num_out_p);
    localparam int max_k_lp  = (num_in_p < num_out_p) ? num_in_p : num_out_p;

    logic [iptr_w_lp-1:0] iptr_reg, iptr_next;
    logic [optr_w_lp-1:0] optr_reg, optr_next;
    logic [lg_in_lp-1:0]  in_cfg_reg;
    logic [lg_out_lp-1:0] out_cfg_reg;

    int   ni_act, no_act, lim, k, ich, och, eff_iptr, eff_optr;
    logic cfg_change, scan_run, slot_in_v, slot_out_f;
    logic [width_p-1:0]   slot_data;
    logic [num_in_p-1:0]  yumi_raw;
    logic [num_out_p-1:0] obuf_push, obuf_free;
    logic [width_p-1:0]   obuf_wdata [num_out_p];

    // Resolve active counts (0 or too large means all channels) and detect a config change
    always_comb begin
        ni_act = int'(in_active_i);
        if (ni_act == 0 || ni_act > num_in_p) begin
            ni_act = num_in_p;
        end
        no_act = int'(out_active_i);
        if (no_act == 0 || no_act > num_out_p) begin
            no_act = num_out_p;
        end
        lim        = (ni_act < no_act) ? ni_act : no_act;
        cfg_change = (lg_in_lp'(ni_act) != in_cfg_reg) || (lg_out_lp'(no_act) != out_cfg_reg);
        // A changed config restarts both rotations at channel 0 this very cycle
        eff_iptr   = cfg_change ? 0 : int'(iptr_reg);
        eff_optr   = cfg_change ? 0 : int'(optr_reg);
    end

    // Rotate both views into slot order and AND-scan valid/free to get the transfer count k
    always_comb begin
        k          = 0;
        scan_run   = 1'b1;
        yumi_raw   = '0;
        obuf_push  = '0;
        ich        = 0;
        och        = 0;
        slot_in_v  = 1'b0;
        slot_out_f = 1'b0;
        slot_data  = '0;
        for (int c = 0; c < num_out_p; c++) begin
            obuf_wdata[c] = '0;
        end
        for (int j = 0; j < max_k_lp; j++) begin
            ich = eff_iptr + j;
            if (ich >= ni_act) ich = ich - ni_act;
            och = eff_optr + j;
            if (och >= no_act) och = och - no_act;
            slot_in_v  = 1'b0;
            slot_out_f = 1'b0;
            slot_data  = '0;
            for (int c = 0; c < num_in_p; c++) begin
                if (c == ich) begin
                    slot_in_v = valid_i[c];
                    slot_data = data_i[c*width_p +: width_p];
                end
            end
            for (int c = 0; c < num_out_p; c++) begin
                if (c == och) slot_out_f = obuf_free[c];
            end
            if (scan_run && (j < lim) && slot_in_v && slot_out_f) begin
                k = j + 1;
                for (int c = 0; c < num_in_p; c++) begin
                    if (c == ich) yumi_raw[c] = 1'b1;
                end
                for (int c = 0; c < num_out_p; c++) begin
                    if (c == och) begin
                        obuf_push[c]  = 1'b1;
                        obuf_wdata[c] = slot_data;
                    end
                end
            end else begin
                scan_run = 1'b0;
            end
        end
    end

    // Async reset must silence the consume handshake immediately, not at the next edge
    assign yumi_o     = reset_n ? yumi_raw : '0;
    assign xfer_cnt_o = reset_n ? lg_in_lp'(k) : '0;
    assign iptr_next  = iptr_w_lp'(rr_add(eff_iptr, k, ni_act));
    assign optr_next  = optr_w_lp'(rr_add(eff_optr, k, no_act));

    // Round-robin pointers and the last-seen config for change detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iptr_reg    <= '0;
            optr_reg    <= '0;
            in_cfg_reg  <= lg_in_lp'(num_in_p);
            out_cfg_reg <= lg_out_lp'(num_out_p);
        end else begin
            iptr_reg    <= iptr_next;
            optr_reg    <= optr_next;
            in_cfg_reg  <= lg_in_lp'(ni_act);
            out_cfg_reg <= lg_out_lp'(no_act);
        end
    end

    // Flag out-of-range active counts in simulation
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (in_active_i != '0 && int'(in_active_i) <= num_in_p);
            assert (out_active_i != '0 && int'(out_active_i) <= num_out_p);
        end
    end

    for (genvar gi = 0; gi < num_out_p; gi++) begin : g_obuf
        bsg_rr_f2f_obuf #(
            .width_p (width_p)
        ) obuf (
            .clk     (clk),
            .reset_n (reset_n),
            .v_i     (obuf_push[gi]),
            .data_i  (obuf_wdata[gi]),
            .free_o  (obuf_free[gi]),
            .valid_o (valid_o[gi]),
            .data_o  (data_o[gi*width_p +: width_p]),
            .ready_i (ready_i[gi])
        );
    end

endmodule
